// File: rtl/dequantize_array_if.sv
// Scale, code-beat and FP-beat channels of the tile dequantizer.
// The slave modport is the dequantizer; the master modport is whoever feeds and drains it.
interface dequantize_array_if #(
  parameter int unsigned MAT_SIZE  = 16,
  parameter int unsigned FP_DATA_W = 32,
  parameter int unsigned FP_EXP_W  = 8,
  parameter int unsigned FP_MANT_W = 23,
  parameter int unsigned LANES_NUM = 16
);

  logic                             scl_valid_i;
  logic                             scl_ready_o;
  logic [FP_MANT_W*MAT_SIZE-1:0]    mantissa_scale_i;
  logic [FP_EXP_W*MAT_SIZE-1:0]     exp_scale_i;

  logic                             s_valid_i;
  logic                             s_ready_o;
  logic [LANES_NUM*FP_DATA_W-1:0]   s_data_i;

  logic                             m_valid_o;
  logic                             m_ready_i;
  logic [LANES_NUM*FP_DATA_W-1:0]   m_data_o;

  modport slave (
    input  scl_valid_i, mantissa_scale_i, exp_scale_i, s_valid_i, s_data_i, m_ready_i,
    output scl_ready_o, s_ready_o, m_valid_o, m_data_o
  );

  modport master (
    output scl_valid_i, mantissa_scale_i, exp_scale_i, s_valid_i, s_data_i, m_ready_i,
    input  scl_ready_o, s_ready_o, m_valid_o, m_data_o
  );

endinterface

// File: rtl/dequantize_array.sv
// Tile dequantizer: per-row FP32 scales times signed integer codes, emitted as binary32 lanes.
// One registered output stage; a new code beat is taken only when that stage is free or draining.
module dequantize_array #(
  parameter int unsigned BIT_NUM     = 8,
  parameter int unsigned MAT_SIZE    = 16,
  parameter int unsigned FP_DATA_W   = 32,
  parameter int unsigned FP_EXP_W    = 8,
  parameter int unsigned FP_MANT_W   = 23,
  parameter int unsigned FP_EXP_BIAS = 127,
  parameter int unsigned LANES_NUM   = 16
) (
  input  logic                 clk,
  input  logic                 rstnn,
  input  logic                 start_i,
  output logic                 done_o,
  dequantize_array_if.slave    bus
);

  localparam int BitN  = int'(BIT_NUM);
  localparam int MatSz = int'(MAT_SIZE);
  localparam int FpW   = int'(FP_DATA_W);
  localparam int ExpW  = int'(FP_EXP_W);
  localparam int MantW = int'(FP_MANT_W);
  localparam int Bias  = int'(FP_EXP_BIAS);
  localparam int Lanes = int'(LANES_NUM);
  localparam int Elems = MatSz * MatSz;
  localparam int Beats = (Elems + Lanes - 1) / Lanes;
  localparam int BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int SigW  = MantW + 1;
  localparam int ProdW = BitN + SigW;

  localparam logic [BeatW-1:0]     LastBeat = BeatW'(Beats - 1);
  localparam logic [FP_DATA_W-1:0] QNaN     =
      FP_DATA_W'({1'b0, {FP_EXP_W{1'b1}}, 1'b1, {(FP_MANT_W - 1){1'b0}}});

  typedef enum logic [1:0] {StIdle, StScale, StRun, StDrain} state_e;

  state_e                         state_q, state_d;
  logic [BeatW-1:0]               in_beat_q, in_beat_d;
  logic [MantW*MatSz-1:0]         mant_scale_q, mant_scale_d;
  logic [ExpW*MatSz-1:0]          exp_scale_q, exp_scale_d;
  logic                           m_valid_q, m_valid_d;
  logic [Lanes*FpW-1:0]           m_data_q, m_data_d;
  logic                           done_q, done_d;
  logic [Lanes*FpW-1:0]           lane_data;

  logic scl_ready, s_ready;
  logic scl_acc, s_acc, m_acc;

  // Only the low BIT_NUM bits of each lane carry a code.
  logic unused_data;
  assign unused_data = ^bus.s_data_i;

  function automatic int elem_idx(input logic [BeatW-1:0] beat, input int lane);
    return int'(beat) * Lanes + lane;
  endfunction

  // q * {1,mant} * 2^(e-bias-23) * 2^-(BIT_NUM-1), rounded to nearest-even on 24 bits.
  function automatic logic [FP_DATA_W-1:0] dequant_lane(
    input logic [BIT_NUM-1:0]   q,
    input logic [FP_EXP_W-1:0]  e,
    input logic [FP_MANT_W-1:0] mant
  );
    logic                 sign;
    logic [BIT_NUM-1:0]   mag;
    logic [ProdW-1:0]     prod;
    logic [SigW-1:0]      sig;
    logic [SigW:0]        rnd;
    logic [FP_MANT_W-1:0] frac;
    logic                 guard, sticky;
    int                   lead, sh, exp_unb, exp_r;
    logic [FP_DATA_W-1:0] res;

    sign = q[BIT_NUM-1];
    mag  = sign ? (~q + 1'b1) : q;
    prod = ProdW'(mag) * ProdW'({1'b1, mant});

    lead = 0;
    for (int i = 0; i < ProdW; i++) begin
      if (prod[i]) lead = i;
    end
    sh = lead - MantW;

    guard  = 1'b0;
    sticky = 1'b0;
    for (int i = 0; i < ProdW; i++) begin
      if (i == sh - 1) guard = prod[i];
      if (i < sh - 1)  sticky = sticky | prod[i];
    end

    sig = SigW'(prod >> sh);
    rnd = {1'b0, sig} + (SigW + 1)'(guard & (sticky | sig[0]));
    frac = rnd[SigW] ? rnd[SigW-1:1] : rnd[MantW-1:0];

    exp_unb = (int'(e) - Bias) - (BitN - 1) + (lead - MantW);
    exp_r   = exp_unb + Bias + int'(rnd[SigW]);

    if (q == '0 || e == '0) begin
      res = '0;
    end else if (e == '1) begin
      res = QNaN;
    end else if (exp_r <= 0) begin
      res = {sign, {(FP_DATA_W - 1){1'b0}}};
    end else begin
      res = {sign, FP_EXP_W'(exp_r), frac};
    end
    return res;
  endfunction

  always_comb begin
    lane_data = '0;
    for (int l = 0; l < Lanes; l++) begin
      if (elem_idx(in_beat_q, l) < Elems) begin
        lane_data[l*FpW +: FpW] = dequant_lane(
            bus.s_data_i[l*FpW +: BitN],
            exp_scale_q[(elem_idx(in_beat_q, l) / MatSz) * ExpW +: ExpW],
            mant_scale_q[(elem_idx(in_beat_q, l) / MatSz) * MantW +: MantW]);
      end
    end
  end

  assign scl_ready = (state_q == StScale);
  assign s_ready   = (state_q == StRun) && (!m_valid_q || bus.m_ready_i);
  assign scl_acc   = bus.scl_valid_i && scl_ready;
  assign s_acc     = bus.s_valid_i && s_ready;
  assign m_acc     = m_valid_q && bus.m_ready_i;

  always_comb begin
    state_d      = state_q;
    in_beat_d    = in_beat_q;
    mant_scale_d = mant_scale_q;
    exp_scale_d  = exp_scale_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    done_d       = 1'b0;

    // A reload in the same cycle as an accept keeps the stage full.
    if (m_acc) m_valid_d = 1'b0;
    if (s_acc) begin
      m_valid_d = 1'b1;
      m_data_d  = lane_data;
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StScale;
      end
      StScale: begin
        if (scl_acc) begin
          mant_scale_d = bus.mantissa_scale_i;
          exp_scale_d  = bus.exp_scale_i;
          state_d      = StRun;
        end
      end
      StRun: begin
        if (s_acc) begin
          if (in_beat_q == LastBeat) begin
            in_beat_d = '0;
            state_d   = StDrain;
          end else begin
            in_beat_d = in_beat_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (m_acc) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstnn) begin
      state_q      <= StIdle;
      in_beat_q    <= '0;
      mant_scale_q <= '0;
      exp_scale_q  <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_beat_q    <= in_beat_d;
      mant_scale_q <= mant_scale_d;
      exp_scale_q  <= exp_scale_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      done_q       <= done_d;
    end
  end

  assign bus.scl_ready_o = scl_ready;
  assign bus.s_ready_o   = s_ready;
  assign bus.m_valid_o   = m_valid_q;
  assign bus.m_data_o    = m_data_q;
  assign done_o          = done_q;

endmodule

// File: tb/tb_dequantize_array.sv
// Bench for dequantize_array: directed scale/code table, random tiles against an integer model,
// ready back-pressure, and a mid-tile reset.
module tb_dequantize_array;

  localparam int BitN  = 8;
  localparam int Mat   = 16;
  localparam int FpW   = 32;
  localparam int ExpW  = 8;
  localparam int MantW = 23;
  localparam int Lanes = 16;
  localparam int Elems = Mat * Mat;
  localparam int Beats = (Elems + Lanes - 1) / Lanes;
  localparam int BusW  = Lanes * FpW;

  typedef struct {
    logic [7:0]  e;
    logic [22:0] m;
    logic [7:0]  q;
    logic [31:0] want;
  } vec_t;

  logic clk = 1'b0;
  logic rstnn = 1'b1;
  logic start_i = 1'b0;
  logic done_o;

  dequantize_array_if #(
    .MAT_SIZE(Mat), .FP_DATA_W(FpW), .FP_EXP_W(ExpW), .FP_MANT_W(MantW), .LANES_NUM(Lanes)
  ) bus ();

  dequantize_array #(
    .BIT_NUM(BitN), .MAT_SIZE(Mat), .FP_DATA_W(FpW), .FP_EXP_W(ExpW), .FP_MANT_W(MantW),
    .FP_EXP_BIAS(127), .LANES_NUM(Lanes)
  ) dut (
    .clk(clk),
    .rstnn(rstnn),
    .start_i(start_i),
    .done_o(done_o),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  vec_t            vecs[Mat];
  logic [7:0]      tile_e[Mat];
  logic [22:0]     tile_m[Mat];
  logic [BusW-1:0] tile_data[Beats];
  logic [BusW-1:0] want_beat[Beats];
  logic [BusW-1:0] got_beat[Beats];

  task automatic check(input string name, input logic [BusW-1:0] act, input logic [BusW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // value = q * (2^23 + m) * 2^(e - 127 - 23 - 7), rounded to 24 significant bits, ties to even.
  function automatic logic [31:0] ref_lane(input logic [7:0] q, input logic [7:0] e,
                                           input logic [22:0] m);
    longint mag, p, top, rem, half;
    int n, d, ex;
    logic neg;
    logic [31:0] r;
    neg = q[7];
    mag = neg ? 256 - longint'(q) : longint'(q);
    if (mag == 0 || e == 8'h00) return 32'h0;
    if (e == 8'hFF) return 32'h7FC00000;
    p = mag * (longint'(m) + 64'sd8388608);
    n = 0;
    while ((p >> (n + 1)) != 0) n++;
    d = n - 23;
    top = p >> d;
    rem = p - (top << d);
    if (d > 0) begin
      half = longint'(1) << (d - 1);
      if (rem > half || (rem == half && top[0])) top++;
    end
    if (top == (longint'(1) << 24)) begin
      top = top >> 1;
      n++;
    end
    ex = int'(e) - 7 + n - 23;
    if (ex <= 0) return {neg, 31'h0};
    r = {neg, ex[7:0], top[22:0]};
    return r;
  endfunction

  task automatic build_expected();
    int elem;
    for (int b = 0; b < Beats; b++) begin
      want_beat[b] = '0;
      for (int l = 0; l < Lanes; l++) begin
        elem = b * Lanes + l;
        if (elem < Elems)
          want_beat[b][l*FpW +: FpW] = ref_lane(tile_data[b][l*FpW +: BitN],
                                                tile_e[elem / Mat], tile_m[elem / Mat]);
      end
    end
  endtask

  task automatic rand_data();
    for (int b = 0; b < Beats; b++)
      for (int w = 0; w < Lanes; w++) tile_data[b][w*FpW +: FpW] = $urandom;
  endtask

  task automatic rand_scales();
    int k;
    for (int r = 0; r < Mat; r++) begin
      k = $urandom_range(0, 15);
      tile_e[r] = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : 8'($urandom_range(20, 254));
      tile_m[r] = 23'($urandom);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " m_valid"}, BusW'(bus.m_valid_o), '0);
    check({tag, " m_data"}, bus.m_data_o, '0);
    check({tag, " s_ready"}, BusW'(bus.s_ready_o), '0);
    check({tag, " scl_ready"}, BusW'(bus.scl_ready_o), '0);
    check({tag, " done"}, BusW'(done_o), '0);
  endtask

  // ready_mode: 0 always ready, 1 toggle 1/0, 2 random. abort_at >= 0 leaves after that many
  // code beats have been accepted.
  task automatic run_tile(input int ready_mode, input int abort_at, output int n_out);
    int in_idx, cyc, early_done;
    bit held, s_acc, m_acc, fin;
    logic [BusW-1:0] held_data;
    in_idx = 0; n_out = 0; held = 0; fin = 0; early_done = 0;
    for (int r = 0; r < Mat; r++) begin
      bus.mantissa_scale_i[r*MantW +: MantW] = tile_m[r];
      bus.exp_scale_i[r*ExpW +: ExpW] = tile_e[r];
    end
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    bus.scl_valid_i = 1'b1;
    check("scl_ready in scale", BusW'(bus.scl_ready_o), BusW'(1));
    @(posedge clk); #1;
    bus.scl_valid_i = 1'b0;
    cyc = 0;
    while (!fin && cyc < 400) begin
      bus.s_valid_i = (in_idx < Beats);
      bus.s_data_i  = (in_idx < Beats) ? tile_data[in_idx] : BusW'($urandom);
      bus.m_ready_i = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? ~cyc[0]
                                                                  : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (held) check("held beat stable", {bus.m_data_o[BusW-1:1], bus.m_valid_o}, 
                      {held_data[BusW-1:1], 1'b1});
      m_acc = bus.m_valid_o && bus.m_ready_i;
      if (m_acc) begin
        got_beat[n_out] = bus.m_data_o;
        n_out++;
      end
      held = bus.m_valid_o && !bus.m_ready_i;
      held_data = bus.m_data_o;
      if (done_o) early_done++;
      s_acc = bus.s_valid_i && bus.s_ready_o;
      @(posedge clk); #1;
      if (s_acc) in_idx++;
      if (m_acc && n_out == Beats) fin = 1;
      cyc++;
      if (abort_at >= 0 && in_idx == abort_at) break;
    end
    bus.s_valid_i = 1'b0;
    bus.m_ready_i = 1'b0;
    if (abort_at < 0) begin
      check("early done pulses", BusW'(early_done), '0);
      if (!fin) check("tile finished beats", BusW'(n_out), BusW'(Beats));
      else begin
        check("done after last beat", BusW'(done_o), BusW'(1));
        check("m_valid cleared", BusW'(bus.m_valid_o), '0);
        check("idle after tile", BusW'({bus.scl_ready_o, bus.s_ready_o}), '0);
        @(posedge clk); #1;
        check("done one cycle", BusW'(done_o), '0);
      end
    end
  endtask

  task automatic compare_tile(input string tag, input int n_out);
    check({tag, " beat count"}, BusW'(n_out), BusW'(Beats));
    for (int b = 0; b < Beats && b < n_out; b++)
      check($sformatf("%s beat %0d", tag, b), got_beat[b], want_beat[b]);
  endtask

  initial begin
    int n_out;
    vecs[0]  = '{8'd127, 23'h000000, 8'd64,  32'h3F000000};
    vecs[1]  = '{8'd127, 23'h000000, 8'h80,  32'hBF800000};
    vecs[2]  = '{8'd127, 23'h000000, 8'd127, 32'h3F7E0000};
    vecs[3]  = '{8'd127, 23'h000000, 8'd0,   32'h00000000};
    vecs[4]  = '{8'd127, 23'h400000, 8'd3,   32'h3D100000};
    vecs[5]  = '{8'd127, 23'h400000, 8'hFD,  32'hBD100000};
    vecs[6]  = '{8'd127, 23'h000001, 8'd3,   32'h3CC00002};
    vecs[7]  = '{8'd0,   23'h000123, 8'd5,   32'h00000000};
    vecs[8]  = '{8'd255, 23'h000000, 8'd1,   32'h7FC00000};
    vecs[9]  = '{8'd255, 23'h000000, 8'd0,   32'h00000000};
    vecs[10] = '{8'd1,   23'h000000, 8'd1,   32'h00000000};
    vecs[11] = '{8'd1,   23'h000000, 8'hFF,  32'h80000000};
    vecs[12] = '{8'd8,   23'h000000, 8'd1,   32'h00800000};
    vecs[13] = '{8'd127, 23'h000003, 8'd3,   32'h3CC00004};
    vecs[14] = '{8'd127, 23'h000001, 8'd7,   32'h3D600002};
    vecs[15] = '{8'd200, 23'h123456, 8'hFF,  32'hE0923456};

    bus.scl_valid_i = 1'b0;
    bus.mantissa_scale_i = '0;
    bus.exp_scale_i = '0;
    bus.s_valid_i = 1'b0;
    bus.s_data_i = '0;
    bus.m_ready_i = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rstnn = 1'b0;
    @(posedge clk); #1;

    // Scale and code valids must be ignored while idle.
    bus.scl_valid_i = 1'b1;
    bus.s_valid_i = 1'b1;
    bus.s_data_i = BusW'($urandom);
    @(posedge clk); #1;
    check("idle scl_ready", BusW'(bus.scl_ready_o), '0);
    check("idle s_ready", BusW'(bus.s_ready_o), '0);
    check("idle m_valid", BusW'(bus.m_valid_o), '0);
    bus.scl_valid_i = 1'b0;
    bus.s_valid_i = 1'b0;

    // Directed table: row r uses vecs[r] scale, lane 0 of beat r carries vecs[r].q.
    rand_data();
    for (int r = 0; r < Mat; r++) begin
      tile_e[r] = vecs[r].e;
      tile_m[r] = vecs[r].m;
      tile_data[r][7:0] = vecs[r].q;
    end
    build_expected();
    run_tile(1, -1, n_out);
    for (int r = 0; r < Mat && r < n_out; r++)
      check($sformatf("table vec %0d", r), BusW'(got_beat[r][31:0]), BusW'(vecs[r].want));
    compare_tile("directed", n_out);

    rand_scales();
    rand_data();
    build_expected();
    run_tile(0, -1, n_out);
    compare_tile("random full rate", n_out);

    // Reset for one cycle after beat 5 has been taken.
    rand_scales();
    rand_data();
    run_tile(0, 6, n_out);
    rstnn = 1'b1;
    @(posedge clk); #1;
    rstnn = 1'b0;
    check_reset_outputs("mid-tile reset");

    rand_scales();
    rand_data();
    build_expected();
    run_tile(2, -1, n_out);
    compare_tile("after reset", n_out);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
